// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard receiver: segment encodings,
// scan-code prefixes, frame geometry and the decoded byte classification.
package ps2_kbd_pkg;

  // Active-low 7-segment pattern with every segment and dp dark.
  localparam logic [7:0] BLANK     = 8'hFF;

  // Scan-code prefixes.
  localparam logic [7:0] SCAN_EXT  = 8'hE0;
  localparam logic [7:0] SCAN_BRK  = 8'hF0;

  // Bit count value at which the 11th bit (stop) has been sampled.
  localparam logic [3:0] FRAME_LAST = 4'd10;

  // How a valid received byte affects the make/break decoder.
  typedef enum logic [1:0] {
    BYTE_EXT,
    BYTE_BRK,
    BYTE_RELEASE,
    BYTE_MAKE
  } byte_kind_e;

  // Hex digit to active-low segments; bit0=a .. bit6=g, bit7=dp (off).
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ps2_keyboard_seg_hex_decoder.sv
// One active-low 7-segment digit driver.
//   i_nibble : hex value to show
//   i_blank  : 1 forces all segments off
//   o_seg    : active-low segments, bit0=a .. bit6=g, bit7=dp
module seg_hex_decoder
  import ps2_kbd_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = BLANK;
    if (!i_blank) begin
      o_seg = hex_to_seg(i_nibble);
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with received-byte FIFO, make/break decoder and
// eight 7-segment status digits.
//   clk, rst         : system clock, synchronous active-high reset
//   ps2_clk/ps2_data : asynchronous PS/2 lines
//   nextdata_n       : active-low pop of the FIFO head
//   data/ready       : FIFO head byte / FIFO non-empty
//   overflow         : sticky, a valid byte was dropped on a full FIFO
//   o_seg1/0 last byte, o_seg3/2 held key (blank if none),
//   o_seg5/4 press count, o_seg7/6 frame error count
module ps2_keyboard
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic [7:0] o_seg0,
  output logic [7:0] o_seg1,
  output logic [7:0] o_seg2,
  output logic [7:0] o_seg3,
  output logic [7:0] o_seg4,
  output logic [7:0] o_seg5,
  output logic [7:0] o_seg6,
  output logic [7:0] o_seg7
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------- receiver
  logic [2:0]  r_sync;
  logic [10:0] r_shift;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic        w_fall;

  assign w_fall = r_sync[2] & ~r_sync[1];

  // r_done pulses the cycle after the stop bit lands, so r_shift holds
  // the whole frame (start at bit0, stop at bit10) while it is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], ps2_clk};
      r_done <= 1'b0;
      if (w_fall) begin
        r_shift <= {ps2_data, r_shift[10:1]};
        if (r_cnt == FRAME_LAST) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  logic [7:0] w_byte;
  logic       w_frame_ok;
  logic       w_valid;
  logic       w_bad;

  assign w_byte     = r_shift[8:1];
  assign w_frame_ok = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);
  assign w_valid    = r_done & w_frame_ok;
  assign w_bad      = r_done & ~w_frame_ok;

  // -------------------------------------------------------------------- FIFO
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        r_ovf;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = w_valid & ~w_full;
  assign w_pop   = ~nextdata_n & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= w_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_ONE;
      end
      if (w_valid && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign ready    = ~w_empty;
  assign overflow = r_ovf;

  always_comb begin
    data = '0;
    if (!w_empty) begin
      data = r_mem[r_rd[AW-1:0]];
    end
  end

  // ----------------------------------------------------------------- decoder
  byte_kind_e w_kind;
  logic [7:0] r_last;
  logic [7:0] r_held_code;
  logic       r_held;
  logic       r_brk;
  logic       r_ext;
  logic [7:0] r_press;
  logic [7:0] r_err;

  always_comb begin
    w_kind = BYTE_MAKE;
    if (w_byte == SCAN_EXT) begin
      w_kind = BYTE_EXT;
    end else if (w_byte == SCAN_BRK) begin
      w_kind = BYTE_BRK;
    end else if (r_brk) begin
      w_kind = BYTE_RELEASE;
    end
  end

  // Decoder sees every valid byte, including ones the full FIFO drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= '0;
      r_held_code <= '0;
      r_held      <= 1'b0;
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_press     <= '0;
      r_err       <= '0;
    end else begin
      if (w_bad) begin
        r_err <= r_err + 8'd1;
      end
      if (w_valid) begin
        r_last <= w_byte;
        case (w_kind)
          BYTE_EXT: r_ext <= 1'b1;
          BYTE_BRK: r_brk <= 1'b1;
          BYTE_RELEASE: begin
            if (r_held && (w_byte == r_held_code)) begin
              r_held      <= 1'b0;
              r_held_code <= '0;
            end
            r_brk <= 1'b0;
            r_ext <= 1'b0;
          end
          default: begin
            // Typematic repeat of the held key is not a new press.
            if (!r_held || (w_byte != r_held_code)) begin
              r_press     <= r_press + 8'd1;
              r_held_code <= w_byte;
              r_held      <= 1'b1;
            end
            r_ext <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- displays
  seg_hex_decoder u_seg0 (.i_nibble(r_last[3:0]),      .i_blank(1'b0),    .o_seg(o_seg0));
  seg_hex_decoder u_seg1 (.i_nibble(r_last[7:4]),      .i_blank(1'b0),    .o_seg(o_seg1));
  seg_hex_decoder u_seg2 (.i_nibble(r_held_code[3:0]), .i_blank(~r_held), .o_seg(o_seg2));
  seg_hex_decoder u_seg3 (.i_nibble(r_held_code[7:4]), .i_blank(~r_held), .o_seg(o_seg3));
  seg_hex_decoder u_seg4 (.i_nibble(r_press[3:0]),     .i_blank(1'b0),    .o_seg(o_seg4));
  seg_hex_decoder u_seg5 (.i_nibble(r_press[7:4]),     .i_blank(1'b0),    .o_seg(o_seg5));
  seg_hex_decoder u_seg6 (.i_nibble(r_err[3:0]),       .i_blank(1'b0),    .o_seg(o_seg6));
  seg_hex_decoder u_seg7 (.i_nibble(r_err[7:4]),       .i_blank(1'b0),    .o_seg(o_seg7));

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: PS/2 frames are bit-banged, a
// reference model tracks the expected FIFO contents and display state.
module tb_ps2_keyboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  always #5 clk = ~clk;

  ps2_keyboard #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .o_seg0     (seg0),
    .o_seg1     (seg1),
    .o_seg2     (seg2),
    .o_seg3     (seg3),
    .o_seg4     (seg4),
    .o_seg5     (seg5),
    .o_seg6     (seg6),
    .o_seg7     (seg7)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state; sb is the scoreboard of bytes expected out of the FIFO.
  logic [7:0] sb [$];
  logic [7:0] m_last, m_held_code, m_press, m_err;
  bit         m_held, m_brk, m_ovf;

  function automatic logic [7:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_last = '0; m_held_code = '0; m_press = '0; m_err = '0;
    m_held = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_last = b;
    if (sb.size() < 8) sb.push_back(b);
    else m_ovf = 1'b1;
    if (b == 8'hE0) begin
      // extended prefix only marks the next code
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (m_brk) begin
      if (m_held && b == m_held_code) begin
        m_held = 1'b0;
        m_held_code = '0;
      end
      m_brk = 1'b0;
    end else if (!m_held || b != m_held_code) begin
      m_press++;
      m_held_code = b;
      m_held = 1'b1;
    end
  endtask

  task automatic check_segs(input string tag);
    check_eq({tag, ".seg0"}, seg0, exp_seg(m_last[3:0]));
    check_eq({tag, ".seg1"}, seg1, exp_seg(m_last[7:4]));
    check_eq({tag, ".seg2"}, seg2, m_held ? exp_seg(m_held_code[3:0]) : 8'hFF);
    check_eq({tag, ".seg3"}, seg3, m_held ? exp_seg(m_held_code[7:4]) : 8'hFF);
    check_eq({tag, ".seg4"}, seg4, exp_seg(m_press[3:0]));
    check_eq({tag, ".seg5"}, seg5, exp_seg(m_press[7:4]));
    check_eq({tag, ".seg6"}, seg6, exp_seg(m_err[3:0]));
    check_eq({tag, ".seg7"}, seg7, exp_seg(m_err[7:4]));
    check_eq({tag, ".ovf"},  overflow, m_ovf);
  endtask

  task automatic do_reset();
    ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // Sends the first nbits of a frame (start, D0..D7, parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ~(^b) ^ bad_par;
    f[10]  = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
    ps2_data = 1'b1;
    if (nbits == 11) begin
      if (bad_par) m_err++;
      else model_byte(b);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    int waited = 0;
    while (!ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      check_eq({tag, ".ready_timeout"}, ready, 1'b1);
    end else if (sb.size() == 0) begin
      check_eq({tag, ".unexpected_byte"}, ready, 1'b0);
    end else begin
      check_eq(tag, data, sb.pop_front());
    end
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_eq("rst.ready", ready, 1'b0);
    check_eq("rst.data", data, 8'h00);
    check_eq("rst.seg2", seg2, 8'hFF);
    check_eq("rst.seg0", seg0, 8'hC0);
    check_segs("rst");

    // Single make code 0x1C
    send_frame(8'h1C, 1'b0, 11);
    check_eq("mk.data", data, 8'h1C);
    check_eq("mk.ready", ready, 1'b1);
    check_eq("mk.seg1", seg1, 8'hF9);
    check_eq("mk.seg0", seg0, 8'hC6);
    check_eq("mk.seg3", seg3, 8'hF9);
    check_eq("mk.seg2", seg2, 8'hC6);
    check_eq("mk.seg4", seg4, 8'hF9);
    check_segs("mk");

    // Release: F0 1C
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    check_eq("rel.seg3", seg3, 8'hFF);
    check_eq("rel.seg2", seg2, 8'hFF);
    check_eq("rel.seg5", seg5, 8'hC0);
    check_eq("rel.seg4", seg4, 8'hF9);
    check_segs("rel");
    for (int i = 0; i < 3; i++) pop_check("rel.pop");
    check_eq("rel.empty", ready, 1'b0);

    // Typematic repeat
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0, 11);
    check_eq("rep.seg4", seg4, 8'hF9);
    check_eq("rep.seg5", seg5, 8'hC0);
    check_segs("rep");
    for (int i = 0; i < 3; i++) pop_check("rep.pop");
    check_eq("rep.empty", ready, 1'b0);

    // Parity error with one byte already queued
    send_frame(8'h32, 1'b0, 11);
    send_frame(8'h1C, 1'b1, 11);
    check_eq("par.ready", ready, 1'b1);
    check_eq("par.seg6", seg6, 8'hF9);
    check_eq("par.seg7", seg7, 8'hC0);
    check_segs("par");
    pop_check("par.pop");
    check_eq("par.empty", ready, 1'b0);

    // Overflow: nine bytes into an eight-entry FIFO
    do_reset();
    for (int k = 0; k < 9; k++) send_frame(8'h10 + 8'(k), 1'b0, 11);
    check_eq("ovf.flag", overflow, 1'b1);
    check_segs("ovf");
    for (int i = 0; i < 8; i++) pop_check("ovf.pop");
    check_eq("ovf.empty", ready, 1'b0);
    check_eq("ovf.sticky", overflow, 1'b1);

    // Reset mid-frame, then a clean frame
    do_reset();
    send_frame(8'h29, 1'b0, 5);
    do_reset();
    send_frame(8'h29, 1'b0, 11);
    check_eq("mid.data", data, 8'h29);
    check_eq("mid.ready", ready, 1'b1);
    check_eq("mid.seg6", seg6, 8'hC0);
    check_eq("mid.seg7", seg7, 8'hC0);
    check_segs("mid");
    pop_check("mid.pop");
    check_eq("mid.empty", ready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning received-byte FIFO entries (power of two).
REQ-002 SHALL have one clock and a synchronous, active-high reset: port clk, input, 1 bit, system clock; all logic samples on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port ps2_clk, input, 1 bit, asynchronous PS/2 clock line.
REQ-005 SHALL have port ps2_data, input, 1 bit, asynchronous PS/2 data line.
REQ-006 SHALL have port nextdata_n, input, 1 bit, active-low pop request for the FIFO head.
REQ-007 SHALL have port data, output, 8 bits, FIFO head byte; valid only while ready=1.
REQ-008 SHALL have port ready, output, 1 bit, FIFO non-empty.
REQ-009 SHALL have port overflow, output, 1 bit, sticky flag set when a byte is dropped on a full FIFO.
REQ-010 SHALL have ports o_seg0..o_seg7, output, 8 bits each, active-low 7-segment digits; bit0=a ... bit6=g, bit7=dp, always 1.

Function
REQ-011 SHALL pass ps2_clk through a 3-flop synchronizer and detect a falling edge as synced[2]=1 and synced[1]=0.
REQ-012 SHALL, on each falling edge, sample ps2_data into an 11-bit shift register, LSB first, and increment a 4-bit bit count.
- Frame order: start, D0..D7, parity, stop.
REQ-013 SHALL treat a frame as complete at count 10 and clear the count on the same cycle.
REQ-014 SHALL validate a complete frame as: start=0, stop=1, and XOR of D0..D7 and parity = 1 (odd parity).
- Invalid frame: discarded, error counter incremented (8-bit, wraps 255->0).
REQ-015 SHALL write a valid byte to the FIFO tail one cycle after the frame completes.
- FIFO full: byte dropped, overflow set to 1.
- overflow stays set until reset.
REQ-016 SHALL handle nextdata_n=0 with ready=1 by advancing the head next cycle; nextdata_n=0 with ready=0 is ignored.
REQ-017 SHALL allow a simultaneous push and pop, leaving the occupancy unchanged.
REQ-018 SHALL run a byte decoder on every valid byte.
- Byte 0xE0: sets an ext flag; nothing else is affected.
- Byte 0xF0: sets a brk flag.
- Any other byte with brk=1: release; if it equals held_code, held_code is cleared (held=0); brk and ext are cleared.
- Any other byte with brk=0: make.
REQ-019 SHALL handle a make code as follows.
- Code differs from held_code, or held=0: press_count increments (8-bit wrap), held_code takes the code, held=1.
- Code equals held_code with held=1 (typematic repeat): press_count is not incremented.
- ext is cleared after every make.
REQ-020 SHALL drive the displays combinationally from registers as follows.
- seg1/seg0: last valid byte, high/low nibble hex.
- seg3/seg2: held_code hex, or all segments blank (8'hFF) when held=0.
- seg5/seg4: press_count hex.
- seg7/seg6: error count hex.
REQ-021 SHALL use these active-low hex encodings: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.

Reset
REQ-022 SHALL, with rst=1, clear the synchronizer, shift register, bit count, FIFO pointers, overflow, last byte, held_code, held, brk, ext, press_count and error count on the next clk edge.
REQ-023 SHALL give these outputs after reset: ready=0, data=00, seg0/1/4/5/6/7=C0 and seg2/3=FF.
REQ-024 SHALL abandon a partially received frame when reset occurs mid-frame; the next frame is received cleanly.

Structure
REQ-025 SHALL place the hex-to-segment table, BLANK=8'hFF and the scan constants E0 and F0 in a shared package ps2_kbd_pkg.
REQ-026 SHALL implement the digit encoder as one sub-module, seg_hex_decoder, instanced 8 times with a blank input.

Verification
REQ-027 SHALL cover: frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1 from start to stop), then data=1C, ready=1, seg1=F9, seg0=C6, seg3/seg2=F9/C6, seg4=F9.
REQ-028 SHALL cover: frames F0,1C after REQ-027, then seg3=seg2=FF, seg5/seg4 still 1, FIFO holds 3 bytes.
REQ-029 SHALL cover: 0x1C sent three times without a release, then press_count=1.
REQ-030 SHALL cover: frame 0x1C with parity=1, then no push, seg6=F9 (errors=1), ready unchanged.
REQ-031 SHALL cover: 9 valid frames with nextdata_n=1, then overflow=1; pop 8 times, then ready=0 and the bytes are in arrival order.
REQ-032 SHALL cover: rst pulsed after 5 bits of a frame and the full frame 0x29 resent, then data=29 and error count=0.
